// File: rtl/disp_axis_packer.sv
// disp_axis_packer
// Packs 8-bit disparity pixels into 32-bit little-endian AXI-Stream words for
// the DMA. Frame position comes only from the internal column/row counters;
// the input tlast is checked against them but never steers packing.
// Closed words pass through a 2-entry FIFO whose head drives the m_axis port.
module disp_axis_packer #(
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [31:0]          m_axis_tdata,
  output logic [3:0]           m_axis_tkeep,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 err_row_len,
  output logic [15:0]          frame_cnt
);

  localparam logic [11:0] X_LAST = 12'(IMG_W - 1);
  localparam logic [11:0] Y_LAST = 12'(IMG_H - 1);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } outWord_t;

  logic [7:0]  pixel;
  logic [11:0] x, y, xNext;
  logic [23:0] accData;
  logic [1:0]  accCnt, accCntNext;
  logic        accUser;

  logic        sReady, inAcc, lastCol, lastRow, firstPix, closeWord;
  logic        push, pop, nextCloses, readyNext;
  logic        errRowLen;
  logic [15:0] frameCnt;

  outWord_t    newWord, headWord;
  outWord_t    fifoMem [2];
  logic        wrPtr, rdPtr;
  logic [1:0]  fifoCnt, fifoCntNext;
  logic        mValid;

  assign pixel     = s_axis_tdata;
  assign inAcc     = s_axis_tvalid && sReady;
  assign lastCol   = (x == X_LAST);
  assign lastRow   = (y == Y_LAST);
  assign firstPix  = (x == 12'd0) && (y == 12'd0);
  assign closeWord = (accCnt == 2'd3) || lastCol;

  assign mValid    = (fifoCnt != 2'd0);
  assign push      = inAcc && closeWord;
  assign pop       = mValid && m_axis_tready;
  assign headWord  = fifoMem[rdPtr];

  // Word as it would look if the current pixel closes it; unused lanes stay zero.
  always_comb begin
    newWord      = '0;
    newWord.data = {8'd0, accData} | ({24'd0, pixel} << {accCnt, 3'b000});
    newWord.keep = {accCnt == 2'd3, accCnt >= 2'd2, accCnt >= 2'd1, 1'b1};
    newWord.last = lastCol && lastRow;
    newWord.user = accUser || firstPix;
  end

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    fifoCntNext = fifoCnt;
    if (push && !pop) begin
      fifoCntNext = fifoCnt + 2'd1;
    end else if (pop && !push) begin
      fifoCntNext = fifoCnt - 2'd1;
    end
  end

  // Look ahead one pixel: ready stays high while the next pixel can be absorbed,
  // i.e. the FIFO will have room or that pixel only lands in the partial word.
  // This lets 3 bytes collect behind a full FIFO before the input stalls.
  always_comb begin
    xNext      = x;
    accCntNext = accCnt;
    if (inAcc) begin
      xNext      = lastCol ? 12'd0 : x + 12'd1;
      accCntNext = closeWord ? 2'd0 : accCnt + 2'd1;
    end
    nextCloses = (accCntNext == 2'd3) || (xNext == X_LAST);
    readyNext  = (fifoCntNext < 2'd2) || !nextCloses;
  end

  // Position counters, partial word, error flag, FIFO pointers and frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      accData   <= '0;
      accCnt    <= '0;
      accUser   <= 1'b0;
      errRowLen <= 1'b0;
      wrPtr     <= 1'b0;
      rdPtr     <= 1'b0;
      fifoCnt   <= '0;
      sReady    <= 1'b0;
      frameCnt  <= '0;
    end else begin
      if (inAcc) begin
        x <= xNext;
        if (lastCol) begin
          y <= lastRow ? 12'd0 : y + 12'd1;
        end
        if (closeWord) begin
          accData <= '0;
          accUser <= 1'b0;
        end else begin
          accData <= newWord.data[23:0];
          accUser <= newWord.user;
        end
        accCnt <= accCntNext;
        if (s_axis_tlast != lastCol) begin
          errRowLen <= 1'b1;
        end
      end
      if (push) begin
        wrPtr <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
        if (headWord.last) begin
          frameCnt <= frameCnt + 16'd1;
        end
      end
      fifoCnt <= fifoCntNext;
      sReady  <= readyNext;
    end
  end

  // FIFO storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= newWord;
    end
  end

  assign s_axis_tready = sReady;
  assign m_axis_tvalid = mValid;
  assign m_axis_tdata  = mValid ? headWord.data : 32'd0;
  assign m_axis_tkeep  = mValid ? headWord.keep : 4'd0;
  assign m_axis_tlast  = mValid && headWord.last;
  assign m_axis_tuser  = mValid && headWord.user;
  assign err_row_len   = errRowLen;
  assign frame_cnt     = frameCnt;

endmodule
